// File: rtl/sram_arbiter_if.sv
// Bundles the fetch requester, data requester and shared memory bus signals around the SRAM arbiter.
// The master modport is the arbiter's own view. The slave modport is the view of the pipeline and the memory bridge.
interface sram_arbiter_if #(
  parameter int DW = 32
);
  logic          inst_req;
  logic [DW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_ok;
  logic          inst_stall;

  logic          data_req;
  logic [3:0]    data_wen;
  logic [DW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_ok;
  logic          data_stall;

  logic          bus_req;
  logic          bus_wr;
  logic [3:0]    bus_wstrb;
  logic [DW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;
  logic          bus_err;

  modport master (
    input  inst_req, inst_addr,
    output inst_rdata, inst_ok, inst_stall,
    input  data_req, data_wen, data_addr, data_wdata,
    output data_rdata, data_ok, data_stall,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, bus_err,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_rdata, inst_ok, inst_stall,
    output data_req, data_wen, data_addr, data_wdata,
    input  data_rdata, data_ok, data_stall,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata, bus_err,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one two-phase SRAM bus between instruction fetch and data access. Data has fixed priority.
// A waited transfer that sees no data return within TIMEOUT cycles is forced to complete with an error pulse.
module sram_arbiter #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              rst,
  sram_arbiter_if.master   port_if
);
  typedef enum logic [1:0] {IDLE, ADDR, WAIT, DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          grant_q, grant_d;   // 0 = inst, 1 = data
  logic [3:0]    wstrb_q, wstrb_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] inst_rdata_q, inst_rdata_d;
  logic [DW-1:0] data_rdata_q, data_rdata_d;

  logic          granted_req;
  logic          cap_en;
  logic [DW-1:0] cap_val;

  assign granted_req = grant_q ? port_if.data_req : port_if.inst_req;

  // NOTE: every variable gets its default before the case, so paths that do not assign it cannot infer a latch.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wstrb_d = wstrb_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cap_en  = 1'b0;
    cap_val = port_if.bus_rdata;

    case (state_q)
      IDLE: begin
        if (port_if.data_req) begin
          state_d = ADDR;
          grant_d = 1'b1;
          wstrb_d = port_if.data_wen;
          addr_d  = port_if.data_addr;
          wdata_d = port_if.data_wdata;
          err_d   = 1'b0;
        end else if (port_if.inst_req) begin
          state_d = ADDR;
          grant_d = 1'b0;
          wstrb_d = 4'b0000;
          addr_d  = port_if.inst_addr;
          wdata_d = '0;
          err_d   = 1'b0;
        end
      end
      ADDR: begin
        // An accepted address commits the transfer, even if req drops in the same cycle.
        if (port_if.bus_addr_ok) begin
          if (port_if.bus_data_ok) begin
            state_d = DONE;
            cap_en  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = '0;
          end
        end else if (!granted_req) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (port_if.bus_data_ok) begin
          state_d = DONE;
          cap_en  = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          cap_en  = 1'b1;
          cap_val = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write completion leaves the data-side read word untouched.
  always_comb begin
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    if (cap_en) begin
      if (!grant_q)              inst_rdata_d = cap_val;
      else if (wstrb_q == 4'b0)  data_rdata_d = cap_val;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign port_if.bus_req    = (state_q == ADDR);
  assign port_if.bus_wr     = |wstrb_q;
  assign port_if.bus_wstrb  = wstrb_q;
  assign port_if.bus_addr   = addr_q;
  assign port_if.bus_wdata  = wdata_q;
  assign port_if.bus_err    = (state_q == DONE) & err_q;

  assign port_if.inst_ok    = (state_q == DONE) & ~grant_q;
  assign port_if.data_ok    = (state_q == DONE) &  grant_q;
  assign port_if.inst_rdata = inst_rdata_q;
  assign port_if.data_rdata = data_rdata_q;
  assign port_if.inst_stall = port_if.inst_req & ~port_if.inst_ok;
  assign port_if.data_stall = port_if.data_req & ~port_if.data_ok;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: fetch, collision, store, abort, timeout and reset in mid-transfer.
// Inputs change 1 ns after each rising edge. Outputs are sampled 1 ns later still.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  sram_arbiter_if #(.DW(32)) a ();

  sram_arbiter #(.DW(32), .TIMEOUT(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .port_if (a)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a.inst_req = 1'b0; a.inst_addr = '0;
    a.data_req = 1'b0; a.data_wen = 4'b0; a.data_addr = '0; a.data_wdata = '0;
    a.bus_addr_ok = 1'b0; a.bus_data_ok = 1'b0; a.bus_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #2;
    checks++; if ({a.bus_req, a.inst_ok, a.data_ok, a.bus_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b exp=0000", {a.bus_req, a.inst_ok, a.data_ok, a.bus_err}); end
    checks++; if (a.inst_rdata !== 32'h0 || a.data_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0/0", a.inst_rdata, a.data_rdata); end
    checks++; if (a.bus_addr !== 32'h0 || a.bus_wstrb !== 4'h0) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0/0", a.bus_addr, a.bus_wstrb); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    a.inst_req = 1'b1; a.inst_addr = 32'hBFC00000;        // cycle 0
    step();                                               // cycle 1: ADDR
    checks++; if (a.bus_req !== 1'b1 || a.bus_addr !== 32'hBFC00000) begin failures++; $display("FAIL fetch_addr got=%b/%h exp=1/bfc00000", a.bus_req, a.bus_addr); end
    checks++; if (a.bus_wr !== 1'b0) begin failures++; $display("FAIL fetch_wr got=%b exp=0", a.bus_wr); end
    a.bus_addr_ok = 1'b1;
    step();                                               // cycle 2: WAIT
    a.bus_addr_ok = 1'b0; a.bus_data_ok = 1'b1; a.bus_rdata = 32'h3C08BFAF;
    #1;
    checks++; if (a.bus_req !== 1'b0 || a.inst_stall !== 1'b1) begin failures++; $display("FAIL fetch_wait got=%b/%b exp=0/1", a.bus_req, a.inst_stall); end
    step();                                               // cycle 3: DONE
    a.bus_data_ok = 1'b0;
    #1;
    checks++; if (a.inst_ok !== 1'b1 || a.inst_rdata !== 32'h3C08BFAF) begin failures++; $display("FAIL fetch_done got=%b/%h exp=1/3c08bfaf", a.inst_ok, a.inst_rdata); end
    checks++; if (a.inst_stall !== 1'b0 || a.data_ok !== 1'b0) begin failures++; $display("FAIL fetch_stall got=%b/%b exp=0/0", a.inst_stall, a.data_ok); end
    a.inst_req = 1'b0;
    step();                                               // cycle 4: IDLE
    checks++; if (a.inst_ok !== 1'b0 || a.inst_rdata !== 32'h3C08BFAF) begin failures++; $display("FAIL fetch_hold got=%b/%h exp=0/3c08bfaf", a.inst_ok, a.inst_rdata); end
  endtask

  task automatic test_collision();
    a.inst_req = 1'b1; a.inst_addr = 32'hBFC00010;
    a.data_req = 1'b1; a.data_wen = 4'b0; a.data_addr = 32'h80001000;
    step();                                               // ADDR for data
    checks++; if (a.bus_addr !== 32'h80001000 || a.bus_wr !== 1'b0) begin failures++; $display("FAIL coll_first got=%h/%b exp=80001000/0", a.bus_addr, a.bus_wr); end
    a.bus_addr_ok = 1'b1; a.bus_data_ok = 1'b1; a.bus_rdata = 32'h11112222;
    step();                                               // DONE for data
    a.bus_addr_ok = 1'b0; a.bus_data_ok = 1'b0;
    #1;
    checks++; if (a.data_ok !== 1'b1 || a.inst_ok !== 1'b0 || a.data_rdata !== 32'h11112222) begin failures++; $display("FAIL coll_data_done got=%b/%b/%h exp=1/0/11112222", a.data_ok, a.inst_ok, a.data_rdata); end
    checks++; if (a.inst_stall !== 1'b1 || a.inst_rdata !== 32'h3C08BFAF) begin failures++; $display("FAIL coll_inst_wait got=%b/%h exp=1/3c08bfaf", a.inst_stall, a.inst_rdata); end
    a.data_req = 1'b0;
    step();                                               // IDLE
    checks++; if (a.bus_req !== 1'b0) begin failures++; $display("FAIL coll_gap got=%b exp=0", a.bus_req); end
    step();                                               // ADDR for inst
    checks++; if (a.bus_req !== 1'b1 || a.bus_addr !== 32'hBFC00010) begin failures++; $display("FAIL coll_second got=%b/%h exp=1/bfc00010", a.bus_req, a.bus_addr); end
    a.bus_addr_ok = 1'b1; a.bus_data_ok = 1'b1; a.bus_rdata = 32'h33334444;
    step();
    a.bus_addr_ok = 1'b0; a.bus_data_ok = 1'b0;
    #1;
    checks++; if (a.inst_ok !== 1'b1 || a.inst_rdata !== 32'h33334444 || a.data_rdata !== 32'h11112222) begin failures++; $display("FAIL coll_inst_done got=%b/%h/%h exp=1/33334444/11112222", a.inst_ok, a.inst_rdata, a.data_rdata); end
    a.inst_req = 1'b0;
    step();
  endtask

  task automatic test_store();
    a.data_req = 1'b1; a.data_wen = 4'b0011; a.data_addr = 32'h80000004; a.data_wdata = 32'h0000BEEF;
    step();                                               // ADDR
    checks++; if (a.bus_wr !== 1'b1 || a.bus_wstrb !== 4'b0011) begin failures++; $display("FAIL store_strb got=%b/%b exp=1/0011", a.bus_wr, a.bus_wstrb); end
    checks++; if (a.bus_addr !== 32'h80000004 || a.bus_wdata !== 32'h0000BEEF) begin failures++; $display("FAIL store_bus got=%h/%h exp=80000004/0000beef", a.bus_addr, a.bus_wdata); end
    checks++; if (a.data_ok !== 1'b0 || a.data_stall !== 1'b1) begin failures++; $display("FAIL store_early got=%b/%b exp=0/1", a.data_ok, a.data_stall); end
    a.bus_addr_ok = 1'b1; a.bus_data_ok = 1'b1; a.bus_rdata = 32'hDEADDEAD;
    step();                                               // DONE, two cycles after req
    a.bus_addr_ok = 1'b0; a.bus_data_ok = 1'b0;
    #1;
    checks++; if (a.data_ok !== 1'b1 || a.data_rdata !== 32'h11112222) begin failures++; $display("FAIL store_done got=%b/%h exp=1/11112222", a.data_ok, a.data_rdata); end
    a.data_req = 1'b0; a.data_wen = 4'b0;
    step();
  endtask

  task automatic test_abort();
    a.inst_req = 1'b1; a.inst_addr = 32'hBFC00020;
    step();                                               // ADDR, no addr_ok
    checks++; if (a.bus_req !== 1'b1) begin failures++; $display("FAIL abort_addr got=%b exp=1", a.bus_req); end
    a.inst_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (a.bus_req !== 1'b0 || a.inst_ok !== 1'b0) begin failures++; $display("FAIL abort_idle cyc=%0d got=%b/%b exp=0/0", i, a.bus_req, a.inst_ok); end
    end
  endtask

  task automatic test_timeout();
    int  cyc;
    bit  seen;
    a.data_req = 1'b1; a.data_wen = 4'b0; a.data_addr = 32'h80002000;
    step();                                               // ADDR
    a.bus_addr_ok = 1'b1;
    step();                                               // WAIT, counter 0
    a.bus_addr_ok = 1'b0;
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc < 12) begin
      #1;
      if (a.data_ok === 1'b1) seen = 1'b1;
      else begin
        checks++; if (a.bus_err !== 1'b0) begin failures++; $display("FAIL timeout_early_err cyc=%0d got=%b exp=0", cyc, a.bus_err); end
        step();
        cyc++;
      end
    end
    checks++; if (!seen || cyc != 5) begin failures++; $display("FAIL timeout_latency got=%0d seen=%b exp=5", cyc, seen); end
    checks++; if (a.bus_err !== 1'b1 || a.data_rdata !== 32'h0) begin failures++; $display("FAIL timeout_done got=%b/%h exp=1/0", a.bus_err, a.data_rdata); end
    a.data_req = 1'b0;
    step();
    checks++; if (a.bus_err !== 1'b0 || a.data_ok !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b/%b exp=0/0", a.bus_err, a.data_ok); end
  endtask

  task automatic test_reset_mid();
    a.inst_req = 1'b1; a.inst_addr = 32'hBFC00030;
    step();
    a.bus_addr_ok = 1'b1;
    step();                                               // WAIT
    a.bus_addr_ok = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({a.bus_req, a.inst_ok, a.data_ok, a.bus_err} !== 4'b0 || a.inst_rdata !== 32'h0 || a.bus_addr !== 32'h0) begin failures++; $display("FAIL rst_mid got=%b/%h/%h exp=0000/0/0", {a.bus_req, a.inst_ok, a.data_ok, a.bus_err}, a.inst_rdata, a.bus_addr); end
    step();
    rst = 1'b0; a.inst_req = 1'b0;
    a.bus_data_ok = 1'b1; a.bus_rdata = 32'h55555555;
    step();
    a.bus_data_ok = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (a.inst_ok !== 1'b0 || a.bus_req !== 1'b0 || a.inst_rdata !== 32'h0) begin failures++; $display("FAIL rst_late_ok cyc=%0d got=%b/%b/%h exp=0/0/0", i, a.inst_ok, a.bus_req, a.inst_rdata); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_collision();
    test_store();
    test_abort();
    test_timeout();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
